// File: rtl/depthconv_iagu.sv
// rtl/depthconv_iagu.sv - depthwise-conv input address generator (optional DEPTHCONV_IAGU_ERR_EN adds sticky o_err)
module depthconv_iagu #(
  parameter int         ADDR_W         = 13,
  parameter logic [3:0] MODE_DEPTHCONV = 4'd5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calculate,
  input  logic [3:0]        mode,
  input  logic [ADDR_W-1:0] addr_start_d,
  input  logic [7:0]        in_y_length,
  input  logic [7:0]        in_piece,
  input  logic [7:0]        out_y_length,
  input  logic [3:0]        i_kernel,
  input  logic [1:0]        i_stride,
  input  logic              i_group_end,
  output logic [ADDR_W-1:0] o_d_addr,
  output logic              o_rd_en,
  output logic              o_feature_load_end,
  output logic              o_busy,
`ifdef DEPTHCONV_IAGU_ERR_EN
  output logic              o_err,
`endif
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LEND,
    S_WAIT_GROUP,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  // latched layer configuration
  logic [7:0]        iny_q, iny_d;
  logic [7:0]        pn_q, pn_d;
  logic [7:0]        outy_q, outy_d;
  logic [3:0]        k_q, k_d;
  logic [ADDR_W-1:0] plane_size_q, plane_size_d;
  logic [ADDR_W-1:0] win_step_q, win_step_d;

  // loop counters and incremental address bases
  logic [7:0]        x_q, x_d;
  logic [3:0]        ky_q, ky_d;
  logic [7:0]        oy_q, oy_d;
  logic [7:0]        piece_q, piece_d;
  logic [ADDR_W-1:0] plane_base_q, plane_base_d;
  logic [ADDR_W-1:0] win_base_q, win_base_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  // registered outputs
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              lend_q, lend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef DEPTHCONV_IAGU_ERR_EN
  logic              err_q, err_d;
`endif

  // products used only once per layer, at start time
  logic [15:0]       plane_sq;
  logic [9:0]        stride_rows;
  logic [ADDR_W-1:0] nxt_row;
  logic [ADDR_W-1:0] nxt_win;
  logic [ADDR_W-1:0] nxt_plane;

  // next-state, counter and output computation
  always_comb begin
    state_d      = state_q;
    iny_d        = iny_q;
    pn_d         = pn_q;
    outy_d       = outy_q;
    k_d          = k_q;
    plane_size_d = plane_size_q;
    win_step_d   = win_step_q;
    x_d          = x_q;
    ky_d         = ky_q;
    oy_d         = oy_q;
    piece_d      = piece_q;
    plane_base_d = plane_base_q;
    win_base_d   = win_base_q;
    row_base_d   = row_base_q;
    addr_d       = addr_q;
    rd_en_d      = 1'b0;
    lend_d       = 1'b0;
    done_d       = 1'b0;
    plane_sq     = in_y_length * in_y_length;
    stride_rows  = {8'd0, i_stride} * {2'd0, in_y_length};
    nxt_row      = row_base_q + ADDR_W'(iny_q);
    nxt_win      = win_base_q + win_step_q;
    nxt_plane    = plane_base_q + plane_size_q;

    case (state_q)
      S_IDLE: begin
        if (start_calculate && (mode == MODE_DEPTHCONV)) begin
          iny_d        = in_y_length;
          pn_d         = in_piece;
          outy_d       = out_y_length;
          k_d          = i_kernel;
          plane_size_d = plane_sq[ADDR_W-1:0];
          win_step_d   = ADDR_W'(stride_rows);
          x_d          = 8'd0;
          ky_d         = 4'd0;
          oy_d         = 8'd0;
          piece_d      = 8'd0;
          plane_base_d = addr_start_d;
          win_base_d   = addr_start_d;
          row_base_d   = addr_start_d;
          addr_d       = addr_start_d;
          if ((in_piece == 8'd0) || (out_y_length == 8'd0) ||
              (i_kernel == 4'd0) || (in_y_length == 8'd0)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
            rd_en_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (x_q == iny_q - 8'd1) begin
          x_d = 8'd0;
          if (ky_q == k_q - 4'd1) begin
            ky_d    = 4'd0;
            state_d = S_LEND;
            lend_d  = 1'b1;
          end else begin
            ky_d       = ky_q + 4'd1;
            row_base_d = nxt_row;
            addr_d     = nxt_row;
            rd_en_d    = 1'b1;
          end
        end else begin
          x_d     = x_q + 8'd1;
          addr_d  = addr_q + ADDR_W'(1);
          rd_en_d = 1'b1;
        end
      end

      S_LEND: begin
        state_d = S_WAIT_GROUP;
      end

      S_WAIT_GROUP: begin
        if (i_group_end) begin
          if (oy_q == outy_q - 8'd1) begin
            oy_d = 8'd0;
            if (piece_q == pn_q - 8'd1) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else begin
              piece_d      = piece_q + 8'd1;
              plane_base_d = nxt_plane;
              win_base_d   = nxt_plane;
              row_base_d   = nxt_plane;
              addr_d       = nxt_plane;
              state_d      = S_LOAD;
              rd_en_d      = 1'b1;
            end
          end else begin
            oy_d       = oy_q + 8'd1;
            win_base_d = nxt_win;
            row_base_d = nxt_win;
            addr_d     = nxt_win;
            state_d    = S_LOAD;
            rd_en_d    = 1'b1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);

`ifdef DEPTHCONV_IAGU_ERR_EN
    err_d = err_q |
            (i_group_end && (state_q != S_WAIT_GROUP)) |
            (start_calculate && busy_q);
`endif
  end

  // state, counters, configuration and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      iny_q        <= '0;
      pn_q         <= '0;
      outy_q       <= '0;
      k_q          <= '0;
      plane_size_q <= '0;
      win_step_q   <= '0;
      x_q          <= '0;
      ky_q         <= '0;
      oy_q         <= '0;
      piece_q      <= '0;
      plane_base_q <= '0;
      win_base_q   <= '0;
      row_base_q   <= '0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      lend_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef DEPTHCONV_IAGU_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      iny_q        <= iny_d;
      pn_q         <= pn_d;
      outy_q       <= outy_d;
      k_q          <= k_d;
      plane_size_q <= plane_size_d;
      win_step_q   <= win_step_d;
      x_q          <= x_d;
      ky_q         <= ky_d;
      oy_q         <= oy_d;
      piece_q      <= piece_d;
      plane_base_q <= plane_base_d;
      win_base_q   <= win_base_d;
      row_base_q   <= row_base_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      lend_q       <= lend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef DEPTHCONV_IAGU_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign o_d_addr           = addr_q;
  assign o_rd_en            = rd_en_q;
  assign o_feature_load_end = lend_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
`ifdef DEPTHCONV_IAGU_ERR_EN
  assign o_err              = err_q;
`endif

endmodule

// File: tb/tb_depthconv_iagu.sv
// tb/tb_depthconv_iagu.sv - self-checking bench for depthconv_iagu (DEPTHCONV_IAGU_ERR_EN aware)
module tb_depthconv_iagu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_calculate;
  logic [3:0]  mode;
  logic [12:0] addr_start_d;
  logic [7:0]  in_y_length;
  logic [7:0]  in_piece;
  logic [7:0]  out_y_length;
  logic [3:0]  i_kernel;
  logic [1:0]  i_stride;
  logic        i_group_end;
  logic [12:0] o_d_addr;
  logic        o_rd_en;
  logic        o_feature_load_end;
  logic        o_busy;
  logic        o_done;
`ifdef DEPTHCONV_IAGU_ERR_EN
  logic        o_err;
`endif

  always #5 clk = ~clk;

  depthconv_iagu dut (
    .clk                (clk),
    .rst                (rst),
    .start_calculate    (start_calculate),
    .mode               (mode),
    .addr_start_d       (addr_start_d),
    .in_y_length        (in_y_length),
    .in_piece           (in_piece),
    .out_y_length       (out_y_length),
    .i_kernel           (i_kernel),
    .i_stride           (i_stride),
    .i_group_end        (i_group_end),
    .o_d_addr           (o_d_addr),
    .o_rd_en            (o_rd_en),
    .o_feature_load_end (o_feature_load_end),
    .o_busy             (o_busy),
`ifdef DEPTHCONV_IAGU_ERR_EN
    .o_err              (o_err),
`endif
    .o_done             (o_done)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [12:0] exp_q[$];
  logic [12:0] rd_log[$];
  int          lend_cnt = 0;
  int          done_cnt = 0;
  logic [12:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // reads the DUT issues are checked, in order, against the model's address list
  always @(negedge clk) begin
    if (!rst) begin
      if (o_rd_en) begin
        rd_log.push_back(o_d_addr);
        if (exp_q.size() == 0) begin
          chk("unexpected_rd", {31'd0, o_rd_en}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd_addr", {19'd0, o_d_addr}, {19'd0, mon_e});
        end
      end
      if (o_feature_load_end) begin
        lend_cnt++;
        chk("lend_with_rd", {31'd0, o_rd_en}, 32'd0);
      end
      if (o_done) done_cnt++;
    end
  end

  // address list straight from the window formula
  task automatic build_exp(input int base, input int iny, input int pn, input int outy,
                           input int k, input int s);
    for (int p = 0; p < pn; p++)
      for (int oy = 0; oy < outy; oy++)
        for (int ky = 0; ky < k; ky++)
          for (int x = 0; x < iny; x++)
            exp_q.push_back(13'((base + p * iny * iny + (oy * s + ky) * iny + x) % 8192));
  endtask

  task automatic set_cfg(input int base, input int iny, input int pn, input int outy,
                         input int k, input int s);
    addr_start_d = 13'(base);
    in_y_length  = 8'(iny);
    in_piece     = 8'(pn);
    out_y_length = 8'(outy);
    i_kernel     = 4'(k);
    i_stride     = 2'(s);
  endtask

  task automatic pulse_start(input logic [3:0] m);
    @(posedge clk); #1;
    mode = m;
    start_calculate = 1'b1;
    @(posedge clk); #1;
    start_calculate = 1'b0;
  endtask

  task automatic pulse_group_end();
    @(posedge clk); #1;
    i_group_end = 1'b1;
    @(posedge clk); #1;
    i_group_end = 1'b0;
  endtask

  task automatic wait_lend(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (o_feature_load_end) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pin(input string name, input int idx, input int val);
    if (rd_log.size() > idx) chk(name, {19'd0, rd_log[idx]}, val);
    else chk({name, "_size"}, rd_log.size(), idx + 1);
  endtask

  task automatic run_layer(input int base, input int iny, input int pn, input int outy,
                           input int k, input int s);
    int  windows;
    int  n;
    bit  ok;
    exp_q.delete();
    rd_log.delete();
    build_exp(base, iny, pn, outy, k, s);
    lend_cnt = 0;
    done_cnt = 0;
    windows  = (iny == 0 || k == 0) ? 0 : pn * outy;
    set_cfg(base, iny, pn, outy, k, s);
    pulse_start(4'd5);
    if (windows == 0) begin
      chk("zero_done", {31'd0, o_done}, 32'd1);
      chk("zero_no_rd", {31'd0, o_rd_en}, 32'd0);
    end else begin
      chk("first_rd_en", {31'd0, o_rd_en}, 32'd1);
      chk("first_addr", {19'd0, o_d_addr}, base % 8192);
      for (int w = 0; w < windows; w++) begin
        wait_lend(n, ok);
        chk("lend_timeout", {31'd0, ok}, 32'd1);
        chk("lend_latency", n, k * iny);
        repeat (2) begin @(posedge clk); #1; end
        pulse_group_end();
        if (w < windows - 1) chk("next_rd_en", {31'd0, o_rd_en}, 32'd1);
        else chk("done_pulse", {31'd0, o_done}, 32'd1);
      end
    end
    @(posedge clk); #1;
    chk("done_width", {31'd0, o_done}, 32'd0);
    chk("busy_after", {31'd0, o_busy}, 32'd0);
    chk("missing_rd", exp_q.size(), 32'd0);
    chk("lend_count", lend_cnt, windows);
    chk("done_count", done_cnt, 32'd1);
  endtask

  initial begin
    int  n;
    bit  ok;
    rst = 1'b1;
    start_calculate = 1'b0;
    mode = 4'd0;
    i_group_end = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", {31'd0, o_rd_en}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_lend", {31'd0, o_feature_load_end}, 32'd0);
    chk("rst_addr", {19'd0, o_d_addr}, 32'd0);
    rst = 1'b0;

    // base configuration: two planes of three windows
    run_layer(0, 5, 2, 3, 3, 1);
    chk("base_total", rd_log.size(), 32'd90);
    pin("base_w1", 15, 5);
    pin("base_w2", 30, 10);
    pin("base_p1", 45, 25);
    pin("base_last", 89, 49);

    // stride 2
    run_layer(0, 5, 1, 2, 3, 2);
    pin("stride_w1", 15, 10);
    pin("stride_last", 29, 24);

    // address wrap
    run_layer(8190, 2, 1, 1, 1, 1);
    pin("wrap_a1", 1, 8191);
    run_layer(8191, 2, 1, 1, 1, 1);
    pin("wrap_b1", 1, 0);

    // other mode is ignored
    exp_q.delete();
    set_cfg(0, 5, 1, 1, 3, 1);
    pulse_start(4'd3);
    repeat (5) begin @(posedge clk); #1; end
    chk("mode3_busy", {31'd0, o_busy}, 32'd0);

    // empty output range
    run_layer(7, 5, 1, 0, 3, 1);

    // reset in the middle of a window
    exp_q.delete();
    build_exp(0, 5, 2, 3, 3, 1);
    set_cfg(0, 5, 2, 3, 3, 1);
    pulse_start(4'd5);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_rd_addr", {19'd0, o_d_addr}, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rd_en", {31'd0, o_rd_en}, 32'd0);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    run_layer(100, 5, 1, 1, 3, 1);

`ifdef DEPTHCONV_IAGU_ERR_EN
    chk("err_clean", {31'd0, o_err}, 32'd0);
`endif

    // group end held through the load phase
    exp_q.delete();
    build_exp(40, 5, 1, 1, 3, 1);
    set_cfg(40, 5, 1, 1, 3, 1);
    lend_cnt = 0;
    pulse_start(4'd5);
    i_group_end = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    i_group_end = 1'b0;
    wait_lend(n, ok);
    chk("hold_lend_timeout", {31'd0, ok}, 32'd1);
    pulse_group_end();
    chk("hold_done", {31'd0, o_done}, 32'd1);
    @(posedge clk); #1;
    chk("hold_missing_rd", exp_q.size(), 32'd0);
    chk("hold_lend_count", lend_cnt, 32'd1);
`ifdef DEPTHCONV_IAGU_ERR_EN
    chk("err_set", {31'd0, o_err}, 32'd1);
    repeat (5) begin @(posedge clk); #1; end
    chk("err_sticky", {31'd0, o_err}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared", {31'd0, o_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/depthconv_iagu.md
Name: depthconv_iagu

Overview:
Input address generation unit for depthwise convolution (mode 5). It pairs with the depthwise weight AGU through a handshake. On start it streams feature-buffer read addresses for one kernel window of rows, then pulses o_feature_load_end. It then waits for the weight AGU's group-end pulse before loading the next output row, iterating over all output rows of all input pieces.

Parameters:
ADDR_W, 13, feature buffer address width
MODE_DEPTHCONV, 4'd5, mode code that enables this unit

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
start_calculate  in  1  one-cycle start pulse from scheduler
mode  in  4  layer mode from decoder
addr_start_d  in  13  feature plane base address
in_y_length  in  8  input row length and row count (square plane, row-major)
in_piece  in  8  number of channel pieces (planes)
out_y_length  in  8  output rows per plane
i_kernel  in  4  kernel height, i.e. rows per window
i_stride  in  2  vertical stride
i_group_end  in  1  one-cycle pulse from weight AGU: window consumed
o_d_addr  out  13  feature buffer read address
o_rd_en  out  1  read enable, qualifies o_d_addr
o_feature_load_end  out  1  one-cycle pulse: window fully issued
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse: layer complete

Behaviour:
- Reset (synchronous; also mid-operation): state goes to IDLE. All outputs are 0, all counters are 0, and the latched configuration is cleared.
- States: IDLE, LOAD, LEND, WAIT_GROUP, FIN.
- IDLE, start_calculate=1 and mode==MODE_DEPTHCONV:
  - latch all config inputs; compute plane_size = in_y_length*in_y_length, truncated to 13 bits
  - if in_piece, out_y_length, i_kernel or in_y_length is 0, go to FIN; otherwise go to LOAD
- IDLE, start with any other mode: ignored.
- start_calculate outside IDLE: ignored.
- LOAD issues i_kernel*in_y_length reads, one per cycle, with o_rd_en=1 and no gaps.
  - Address = addr_start_d + piece*plane_size + (oy*stride + ky)*in_y_length + x, all mod 2^13.
  - x is innermost, then ky.
  - Addresses are built incrementally: plane_base += plane_size, win_base += stride*in_y_length, row_base += in_y_length. No multiplier in the loop.
- First read appears the cycle after the start pulse.
- LOAD goes to LEND after the last read.
- LEND: o_feature_load_end=1 for one cycle, o_rd_en=0; then go to WAIT_GROUP.
- WAIT_GROUP, i_group_end=1:
  - advance oy; if oy wraps past out_y_length-1, reset oy to 0 and advance piece
  - if the last row of the last piece is complete, go to FIN; otherwise go to LOAD
  - first read of the next window appears the cycle after i_group_end
- i_group_end outside WAIT_GROUP is ignored, with no latching.
- FIN: o_done=1 for one cycle, then go to IDLE.
- Windows are not bounds-checked against the plane height; the decoder guarantees (out_y_length-1)*stride + kernel <= in_y_length.
- Address wraps modulo 8192 silently.

Optional Feature:
Macro DEPTHCONV_IAGU_ERR_EN.
- Defined: adds output o_err (1 bit), a sticky protocol-error flag, cleared only by rst. It is set the cycle after either:
  - i_group_end=1 while the state is not WAIT_GROUP, or
  - start_calculate=1 while o_busy=1.
  Normal operation is otherwise unchanged.
- Undefined: the o_err port and its logic are absent; both events are silently ignored.

Test Plan:
- Base config (base 0, in_y 5, piece 2, out_y 3, k 3, stride 1, mode 5), start pulse:
  - cycles 1–15 read addresses 0..14; cycle 16 pulses o_feature_load_end
  - after i_group_end, addresses 5..19; after the next, 10..24; then piece 1 reads 25..39
  - 6 load_end pulses total; o_done one cycle after the 6th i_group_end, then o_busy=0
- Stride 2, out_y 2, in_y 5, k 3, piece 1: window 0 reads 0..14, window 1 reads 10..24, then o_done.
- Wrap: base 8190, in_y 2, k 1, out_y 1, piece 1 → reads 8190, 8191; window ends there.
  - Base 8191, in_y 2 → reads 8191, 0 (wrap).
- Mode 3 start → no reads, o_busy stays 0.
- Config with out_y 0 → o_done one cycle after start, no o_rd_en.
- rst asserted mid-LOAD (after 4 reads) → next cycle o_rd_en=0, o_busy=0.
  - A fresh start then restarts at address addr_start_d.
- i_group_end held during LOAD → address sequence unchanged.
  - With DEPTHCONV_IAGU_ERR_EN, o_err=1 and stays 1 until rst.
